// File: rtl/mem_stage_bus.sv
// M-stage memory unit: decodes and checks a load/store, runs it over a req/ack
// bus shared by data memory and IO, and loads the M/W register when it completes.
// Optional build macro MEM_TIMEOUT_EN adds an ack timeout that reports DBE (code 7).
module mem_stage_bus #(
  parameter logic [31:0] DM_LIMIT = 32'h00003000,
  parameter logic [31:0] IO_BASE  = 32'h00007F00,
  parameter logic [31:0] IO_LIMIT = 32'h00007F20,
  parameter int          WAIT_MAX = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        op_valid_M,
  input  logic        op_load_M,
  input  logic        op_store_M,
  input  logic [1:0]  op_size_M,
  input  logic        op_sext_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  input  logic        exc_in_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_M,
  output logic        exc_M,
  output logic [4:0]  exc_code_M,
  output logic        valid_W,
  output logic [31:0] rdata_W
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
`ifdef MEM_TIMEOUT_EN
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam int         CW       = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);
`endif

  state_t      state, state_next;
  logic        mem, in_dm, in_io, misalign, addr_err, accept;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [1:0]  size_q, off_q;
  logic        sext_q;
  logic [31:0] rdata_q;
`ifdef MEM_TIMEOUT_EN
  logic [CW-1:0] wait_cnt;
  logic          dbe_q, timeout;
`endif

  // Lane select and extension of a returned read word; size 3 behaves as word.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size,
                                         input logic [1:0] off, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'd0:    extend = sext ? {{24{b[7]}}, b} : {24'b0, b};
      2'd1:    extend = sext ? {{16{h[15]}}, h} : {16'b0, h};
      default: extend = w;
    endcase
  endfunction

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mem      = op_valid_M & (op_load_M | op_store_M) & ~exc_in_M;
    in_dm    = addr_M < DM_LIMIT;
    in_io    = (addr_M >= IO_BASE) && (addr_M < IO_LIMIT);
    misalign = ((op_size_M == 2'd1) && addr_M[0]) ||
               (op_size_M[1] && (addr_M[1:0] != 2'b00));
    addr_err = mem && (misalign || !(in_dm || in_io) ||
                       (op_store_M && in_io && !op_size_M[1]));

    be_c    = 4'b1111;
    wdata_c = wdata_M;
    case (op_size_M)
      2'd0: begin
        be_c    = 4'b0001 << addr_M[1:0];
        wdata_c = {4{wdata_M[7:0]}};
      end
      2'd1: begin
        be_c    = addr_M[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_M[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    stall_M    = 1'b0;
    exc_M      = 1'b0;
    exc_code_M = 5'd0;
    accept     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timeout    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (addr_err) begin
          exc_M      = 1'b1;
          exc_code_M = op_store_M ? EXC_ADES : EXC_ADEL;
        end else if (mem) begin
          accept     = 1'b1;
          stall_M    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        stall_M = 1'b1;
        if (bus_ack) begin
          state_next = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
`endif
      end
      DONE: begin
        // The instruction still sitting in M is the one just completed; it is not re-accepted.
        state_next = IDLE;
`ifdef MEM_TIMEOUT_EN
        if (dbe_q) begin
          exc_M      = 1'b1;
          exc_code_M = EXC_DBE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
    if (Reset) begin
      stall_M    = 1'b0;
      exc_M      = 1'b0;
      exc_code_M = 5'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      valid_W   <= 1'b0;
      rdata_W   <= '0;
      size_q    <= '0;
      off_q     <= '0;
      sext_q    <= 1'b0;
      rdata_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt  <= '0;
      dbe_q     <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      valid_W <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus_req   <= 1'b1;
            bus_we    <= op_store_M;
            bus_addr  <= addr_M[31:2];
            bus_be    <= be_c;
            bus_wdata <= wdata_c;
            size_q    <= op_size_M;
            off_q     <= addr_M[1:0];
            sext_q    <= op_sext_M;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
            dbe_q     <= 1'b0;
`endif
          end
        end
        WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            rdata_q <= bus_we ? 32'd0 : extend(bus_rdata, size_q, off_q, sext_q);
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout) begin
            bus_req <= 1'b0;
            dbe_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
`ifdef MEM_TIMEOUT_EN
          if (!dbe_q) begin
            valid_W <= 1'b1;
            rdata_W <= rdata_q;
          end
`else
          valid_W <= 1'b1;
          rdata_W <= rdata_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_bus.sv
// Directed bench for mem_stage_bus: transactions, alignment/range exceptions,
// reset mid-transaction and (with MEM_TIMEOUT_EN) the ack timeout.
module tb_mem_stage_bus;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        op_valid_M, op_load_M, op_store_M, op_sext_M, exc_in_M;
  logic [1:0]  op_size_M;
  logic [31:0] addr_M, wdata_M;
  logic        bus_req, bus_we, bus_ack;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        stall_M, exc_M, valid_W;
  logic [4:0]  exc_code_M;
  logic [31:0] rdata_W;

  int checks = 0;
  int passes = 0;

  mem_stage_bus dut (
    .Clk(Clk), .Reset(Reset),
    .op_valid_M(op_valid_M), .op_load_M(op_load_M), .op_store_M(op_store_M),
    .op_size_M(op_size_M), .op_sext_M(op_sext_M), .addr_M(addr_M),
    .wdata_M(wdata_M), .exc_in_M(exc_in_M),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_M(stall_M), .exc_M(exc_M), .exc_code_M(exc_code_M),
    .valid_W(valid_W), .rdata_W(rdata_W)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    op_valid_M = 1'b0; op_load_M = 1'b0; op_store_M = 1'b0;
    op_size_M  = 2'd0; op_sext_M = 1'b0; exc_in_M  = 1'b0;
    addr_M     = '0;   wdata_M   = '0;
  endtask

  task automatic drive_op(input logic st, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd);
    op_valid_M = 1'b1; op_load_M = ~st; op_store_M = st;
    op_size_M  = sz;   op_sext_M = sx;  addr_M = a; wdata_M = wd;
  endtask

  // Full transaction; ack arrives in WAIT cycle number ack_wait+1.
  task automatic txn(input string tag, input logic st, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd, input int ack_wait,
                     input logic [31:0] rd, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd, input logic [31:0] exp_rw, input int exp_stall);
    int   stall_cnt;
    logic req_ok;
    drive_op(st, sz, sx, a, wd);
    #1;
    stall_cnt = stall_M ? 1 : 0;
    check({tag, "_exc"}, {31'b0, exc_M}, 32'd0);
    step();
    check({tag, "_be"},    {28'b0, bus_be}, {28'b0, exp_be});
    check({tag, "_wdata"}, bus_wdata, exp_wd);
    check({tag, "_addr"},  {2'b0, bus_addr}, {2'b0, a[31:2]});
    check({tag, "_we"},    {31'b0, bus_we}, {31'b0, st});
    req_ok = 1'b1;
    for (int i = 0; i < ack_wait; i++) begin
      if (stall_M) stall_cnt++;
      if (!bus_req) req_ok = 1'b0;
      step();
    end
    if (stall_M) stall_cnt++;
    if (!bus_req) req_ok = 1'b0;
    bus_ack = 1'b1; bus_rdata = rd;
    step();
    bus_ack = 1'b0; bus_rdata = '0;
    check({tag, "_done_req"},   {31'b0, bus_req}, 32'd0);
    check({tag, "_done_stall"}, {31'b0, stall_M}, 32'd0);
    check({tag, "_done_vw"},    {31'b0, valid_W}, 32'd0);
    idle_inputs();
    step();
    check({tag, "_vw"},       {31'b0, valid_W}, 32'd1);
    check({tag, "_rdata_w"},  rdata_W, exp_rw);
    check({tag, "_stalls"},   stall_cnt, exp_stall);
    check({tag, "_req_held"}, {31'b0, req_ok}, 32'd1);
    step();
    check({tag, "_vw_pulse"}, {31'b0, valid_W}, 32'd0);
  endtask

  task automatic addr_error(input string tag, input logic st, input logic [1:0] sz,
                            input logic [31:0] a, input logic [4:0] exp_code);
    drive_op(st, sz, 1'b0, a, 32'h1111_2222);
    #1;
    check({tag, "_exc"},   {31'b0, exc_M}, 32'd1);
    check({tag, "_code"},  {27'b0, exc_code_M}, {27'b0, exp_code});
    check({tag, "_stall"}, {31'b0, stall_M}, 32'd0);
    step();
    check({tag, "_req"}, {31'b0, bus_req}, 32'd0);
    check({tag, "_vw"},  {31'b0, valid_W}, 32'd0);
    idle_inputs();
    step();
  endtask

  initial begin
    Reset = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    idle_inputs();
    @(negedge Clk);
    step();
    check("rst_req",   {31'b0, bus_req}, 32'd0);
    check("rst_be",    {28'b0, bus_be}, 32'd0);
    check("rst_vw",    {31'b0, valid_W}, 32'd0);
    check("rst_rw",    rdata_W, 32'd0);
    check("rst_stall", {31'b0, stall_M}, 32'd0);
    check("rst_exc",   {31'b0, exc_M}, 32'd0);
    Reset = 1'b0;
    step();

    txn("ldw",   1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678,
        4'b1111, 32'h0, 32'h1234_5678, 2);
    txn("ldb_s", 1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0, 0, 32'h80FF_0000,
        4'b1000, 32'h0, 32'hFFFF_FF80, 2);
    txn("ldb_u", 1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 0, 32'h80FF_0000,
        4'b1000, 32'h0, 32'h0000_0080, 2);
    txn("sth",   1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'h0000_ABCD, 3, 32'hDEAD_BEEF,
        4'b1100, 32'hABCD_ABCD, 32'h0, 5);
    txn("ldh_s", 1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 1, 32'hBEEF_1234,
        4'b1100, 32'h0, 32'hFFFF_BEEF, 3);
    txn("stb",   1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_005A, 0, 32'h0,
        4'b0010, 32'h5A5A_5A5A, 32'h0, 2);
    txn("stw_io", 1'b1, 2'd2, 1'b0, 32'h0000_7F1C, 32'hCAFE_F00D, 0, 32'h0,
        4'b1111, 32'hCAFE_F00D, 32'h0, 2);
    txn("ldb_io", 1'b0, 2'd0, 1'b1, 32'h0000_7F01, 32'h0, 0, 32'h0000_7F00,
        4'b0010, 32'h0, 32'h0000_007F, 2);

    addr_error("ldw_mis",  1'b0, 2'd2, 32'h0000_0002, 5'd4);
    addr_error("stb_io",   1'b1, 2'd0, 32'h0000_7F00, 5'd5);
    addr_error("ldw_hole", 1'b0, 2'd2, 32'h0000_5000, 5'd4);
    addr_error("ldh_odd",  1'b0, 2'd1, 32'h0000_0001, 5'd4);
    addr_error("stw_dmlim", 1'b1, 2'd2, 32'h0000_3000, 5'd5);
    addr_error("ldw_iolim", 1'b0, 2'd2, 32'h0000_7F20, 5'd4);

    // Earlier-stage exception suppresses both the bus and the address error.
    drive_op(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0);
    exc_in_M = 1'b1;
    #1;
    check("excin_exc",   {31'b0, exc_M}, 32'd0);
    check("excin_stall", {31'b0, stall_M}, 32'd0);
    step();
    check("excin_req", {31'b0, bus_req}, 32'd0);
    idle_inputs();

    // Stray ack while idle.
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_ack = 1'b0; bus_rdata = '0;
    step();
    check("stray_ack_vw", {31'b0, valid_W}, 32'd0);
    check("stray_ack_rw", rdata_W, 32'h0000_007F);

    // Reset while a transaction is waiting for ack.
    drive_op(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0);
    step();
    check("rstw_req_before", {31'b0, bus_req}, 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    idle_inputs();
    #1;
    check("rstw_req",   {31'b0, bus_req}, 32'd0);
    check("rstw_stall", {31'b0, stall_M}, 32'd0);
    step();
    check("rstw_vw", {31'b0, valid_W}, 32'd0);
    txn("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h0000_0024, 32'h0, 0, 32'hA5A5_0F0F,
        4'b1111, 32'h0, 32'hA5A5_0F0F, 2);

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      drive_op(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0);
      step();
      n = 0;
      while (bus_req && n < 40) begin
        step();
        n++;
      end
      check("to_wait_cycles", n, 15);
      check("to_exc",   {31'b0, exc_M}, 32'd1);
      check("to_code",  {27'b0, exc_code_M}, 32'd7);
      check("to_stall", {31'b0, stall_M}, 32'd0);
      idle_inputs();
      step();
      check("to_vw", {31'b0, valid_W}, 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_bus.md
Name: mem_stage_bus

Overview:
- Parametrised M-stage memory unit that replaces the single-cycle DM/IO access with a request/acknowledge bus shared by data memory and IO devices.
- Decodes address, size and alignment, and raises AdEL/AdES exceptions.
- Generates byte enables and performs load extension.
- Stalls the pipeline while a bus transaction is outstanding, then loads the M/W pipeline register.

Parameters:
- DM_LIMIT, 32'h00003000: first address above data memory; DM covers [0, DM_LIMIT).
- IO_BASE, 32'h00007F00: first IO address.
- IO_LIMIT, 32'h00007F20: first address above IO; IO covers [IO_BASE, IO_LIMIT).
- WAIT_MAX, 15: ack timeout in cycles, used only with MEM_TIMEOUT_EN.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- op_valid_M  in  1  M stage holds a valid instruction
- op_load_M  in  1  instruction is a load
- op_store_M  in  1  instruction is a store
- op_size_M  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- op_sext_M  in  1  sign-extend load
- addr_M  in  32  effective address
- wdata_M  in  32  store data, already forwarded
- exc_in_M  in  1  earlier-stage exception pending on this instruction
- bus_req  out  1  request
- bus_we  out  1  write
- bus_addr  out  30  word address
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned write data
- bus_ack  in  1  acknowledge, one cycle
- bus_rdata  in  32  read word, valid with bus_ack
- stall_M  out  1  freeze F/D/E/M
- exc_M  out  1  exception raised by this block
- exc_code_M  out  5  4 AdEL, 5 AdES, 7 DBE
- valid_W  out  1  W register holds a valid memory result
- rdata_W  out  32  extended load data

Behaviour:
- Clk is the only clock. Reset is synchronous and active-high.
- Reset values: state IDLE; bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, valid_W 0, rdata_W 0, stall_M 0, exc_M 0, exc_code_M 0.
- mem = op_valid_M & (op_load_M | op_store_M) & ~exc_in_M.
- Address error in IDLE (combinational) applies when mem is set and any of these hold:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - address in neither the DM nor the IO range;
  - store to IO with size != word.
- On an address error: exc_M=1, exc_code_M=4 for a load or 5 for a store, no bus activity, stall_M=0. valid_W loads 0 at the clock edge.
- States are IDLE, WAIT and DONE.
- IDLE, mem set and no error ("accept"):
  - stall_M=1.
  - At the edge, latch bus_addr=addr[31:2], bus_we=store, bus_be and bus_wdata, and op_size/op_sext/addr[1:0]; set bus_req=1; go to WAIT.
- WAIT:
  - stall_M=1; bus_req held stable.
  - On bus_ack, capture the extended rdata (stores capture 0), clear bus_req, go to DONE.
- DONE:
  - stall_M=0.
  - At the edge, rdata_W=captured value, valid_W=1, go to IDLE.
  - A new M instruction can be accepted in the following cycle.
- IDLE without mem: valid_W loads 0 each non-stalled edge; rdata_W holds.
- Byte enables (little-endian):
  - byte: be=1<<addr[1:0], wdata = byte replicated to all 4 lanes.
  - half: be=addr[1]?4'b1100:4'b0011, wdata = half replicated.
  - word: be=4'b1111.
- Load extension selects the lane by addr[1:0] / addr[1]. The result is zero- or sign-extended per op_sext; word loads pass through.
- Minimum latency from accept to valid_W: 3 edges with an ack in the first WAIT cycle. Each extra ack wait adds one cycle.
- Simultaneous events:
  - bus_ack outside WAIT is ignored.
  - exc_in_M set suppresses all bus activity and exc_M.
  - Once accepted, a transaction always completes; no flush mid-WAIT.
- Reset mid-WAIT: bus_req drops at the reset edge and no W write occurs.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle without ack.
  - When it reaches WAIT_MAX, bus_req clears and the state goes to DONE with pending DBE.
  - In DONE: exc_M=1, exc_code_M=7, valid_W loads 0.
  - An ack arriving in the same cycle as the timeout wins over the timeout.
- Undefined: no counter; WAIT lasts until bus_ack; code 7 is never produced.

Test Plan:
- Word load addr 0x00000010, ack in 1st WAIT cycle, rdata 0x12345678 -> bus_be=1111; stall_M high 2 cycles; valid_W=1, rdata_W=0x12345678 on the 3rd edge.
- Byte load signed addr 0x00000003, rdata 0x80FF0000 -> be=1000, rdata_W=0xFFFFFF80; the unsigned variant gives 0x00000080.
- Half store addr 0x00000006, wdata 0x0000ABCD, ack after 4 cycles -> be=1100, bus_wdata=0xABCDABCD, stall_M held 5 cycles, bus_req stable throughout.
- Word load addr 0x00000002 -> exc_M=1, code 4, bus_req never rises; byte store addr 0x00007F00 -> code 5; word load addr 0x00005000 -> code 4.
- Reset asserted in WAIT -> next cycle bus_req=0, state IDLE, valid_W=0; the next load proceeds normally.
- MEM_TIMEOUT_EN, WAIT_MAX=15, ack never given -> bus_req drops after 15 WAIT cycles; exc_M=1 code 7 in DONE; valid_W=0.
